m_cache_refill: RTL and testbench
=================================

// Module: m_cache_refill
// PURPOSE
//  Miss handler and line refill for the direct-mapped 2-word-line instruction/data cache.
//  - Watches the cache lookup (w_adr, w_hit) and stalls the pipeline on a miss.
//  - Fetches the two 32-bit words of the line from main memory over a req/rdy handshake.
//  - Writes {valid, tag, word1, word0} into the cache write port in one cycle.
//  Sits between the CPU-side cache lookup and the main-memory port.
// PARAMETERS
//  IDX_W  5  line index width (2**IDX_W lines); TAG_W = 29-IDX_W (localparam, 24 at default)
//  WD_W   -  localparam 65+TAG_W, the cache write-data width (89 at default)
// PORTS
//  w_clk    in   1      clock, all state on posedge
//  w_rst_n  in   1      reset, asynchronous, active-low
//  w_req    in   1      CPU access valid this cycle
//  w_adr    in   32     CPU byte address (also drives the cache lookup)
//  w_hit    in   1      cache hit for w_adr (combinational from cache)
//  w_stall  out  1      hold pipeline; CPU keeps w_adr stable while high
//  w_mreq   out  1      memory read request
//  w_madr   out  32     memory word address (byte address, [1:0]=0)
//  w_mrdy   in   1      memory data valid this cycle (sampled only while w_mreq=1)
//  w_mdata  in   32     memory read data
//  w_we     out  1      cache line write enable
//  w_wadr   out  IDX_W  cache line index to write
//  w_wd     out  WD_W   {1'b1, tag, word@base+4, word@base}
// BEHAVIOUR
//  - Reset (async, w_rst_n=0): state IDLE; w_mreq=0, w_we=0, w_madr=0, w_wadr=0, w_wd=0, data regs=0.
//  - States: IDLE, FETCH0, FETCH1, FILL.
//    IDLE:   w_req & ~w_hit -> latch line base {w_adr[31:3],3'b0} and index w_adr[IDX_W+2:3]; go FETCH0.
//    FETCH0: w_mreq=1, w_madr=first word; w_mrdy -> store w_mdata, go FETCH1; else stay.
//    FETCH1: w_mreq=1, w_madr=second word; w_mrdy -> store w_mdata, go FILL; else stay.
//    FILL:   w_we=1 for exactly one cycle, w_wadr=latched index, w_wd assembled; go IDLE.
//  - w_stall = (state!=IDLE) | (w_req & ~w_hit); combinational, so the miss stalls in the detect cycle.
//  - Word placement: word at base+0 -> w_wd[31:0]; word at base+4 -> w_wd[63:32]; tag = base[31:IDX_W+3].
//  - Zero-wait memory: miss penalty 4 stall cycles (detect, FETCH0, FETCH1, FILL); IDLE next cycle hits.
//  - w_madr and w_mreq are stable until the w_mrdy cycle; w_mrdy with w_mreq=0 is ignored.
//  - w_adr/w_req changes outside IDLE are ignored; refill uses latched values only.
//  - w_we=0 and w_mreq=0 in IDLE; a hit in IDLE produces no memory traffic.
//  - Back-to-back misses: IDLE re-evaluates lookup the cycle after FILL; a new miss starts immediately.
//  - Reset mid-refill: abort at once, no cache write, partial data discarded.
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN defined: FETCH0 fetches the word at {base[31:3], adr[2], 2'b0}, FETCH1 the other;
//   data is still placed by address in w_wd, so the written line is identical.
//  Not defined: FETCH0 always base+0, FETCH1 base+4.
// TESTING
//  1 Reset: w_rst_n=0 mid-FETCH1 -> outputs 0 immediately, no w_we pulse after release, state IDLE.
//  2 Miss, zero-wait mem, w_adr=0x0000_1234 -> w_madr 0x1230 then 0x1234; FILL: w_wadr=6,
//    w_wd={1,24'h000012,mem[0x1234],mem[0x1230]}; w_stall high exactly 4 cycles.
//  3 Wait states: w_mrdy low 3 cycles per word -> w_madr/w_mreq held, 10 stall cycles total, same w_wd.
//  4 Hit: w_req=1, w_hit=1 -> w_stall=0, w_mreq=0, w_we=0 every cycle.
//  5 Address change: w_adr switched to 0xFFFF_FF00 during FETCH0 -> refill still writes line for original address.
//  6 CRITICAL_WORD_FIRST_EN, w_adr=0x0000_1234 -> w_madr 0x1234 then 0x1230; w_wd identical to test 2.

Source files
------------

// File: rtl/m_cache_refill.sv
// Miss handler / two-word line refill for the direct-mapped cache.
// Optional: `define CRITICAL_WORD_FIRST_EN fetches the addressed word first.
module m_cache_refill #(
  parameter  int IDX_W = 5,
  localparam int TAG_W = 29 - IDX_W,
  localparam int WD_W  = 65 + TAG_W
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_req,
  input  logic [31:0]       w_adr,
  input  logic              w_hit,
  output logic              w_stall,
  output logic              w_mreq,
  output logic [31:0]       w_madr,
  input  logic              w_mrdy,
  input  logic [31:0]       w_mdata,
  output logic              w_we,
  output logic [IDX_W-1:0]  w_wadr,
  output logic [WD_W-1:0]   w_wd
);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, FILL} state_t;

  state_t      state_q, state_d;
  logic [28:0] base_q, base_d;
  logic [31:0] word0_q, word0_d;
  logic [31:0] word1_q, word1_d;
  logic        first_hi;
  logic        unused_adr;

  assign unused_adr = ^w_adr[2:0];

`ifdef CRITICAL_WORD_FIRST_EN
  logic crit_q, crit_d;
  assign first_hi = crit_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) crit_q <= 1'b0;
    else          crit_q <= crit_d;
  end
`else
  assign first_hi = 1'b0;
`endif

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    word0_d = word0_q;
    word1_d = word1_q;
`ifdef CRITICAL_WORD_FIRST_EN
    crit_d  = crit_q;
`endif
    w_mreq  = 1'b0;
    w_madr  = '0;
    w_we    = 1'b0;
    w_wadr  = '0;
    w_wd    = '0;
    w_stall = (state_q != IDLE) | (w_req & ~w_hit);

    case (state_q)
      IDLE: begin
        if (w_req && !w_hit) begin
          base_d  = w_adr[31:3];
`ifdef CRITICAL_WORD_FIRST_EN
          crit_d  = w_adr[2];
`endif
          state_d = FETCH0;
        end
      end
      FETCH0: begin
        w_mreq = 1'b1;
        w_madr = {base_q, first_hi, 2'b00};
        if (w_mrdy) begin
          // Data lands by address, not by fetch order.
          if (first_hi) word1_d = w_mdata;
          else          word0_d = w_mdata;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        w_mreq = 1'b1;
        w_madr = {base_q, ~first_hi, 2'b00};
        if (w_mrdy) begin
          if (first_hi) word0_d = w_mdata;
          else          word1_d = w_mdata;
          state_d = FILL;
        end
      end
      FILL: begin
        w_we    = 1'b1;
        w_wadr  = base_q[IDX_W-1:0];
        w_wd    = {1'b1, base_q[28:IDX_W], word1_q, word0_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_cache_refill.sv
// Randomized self-checking bench for m_cache_refill against a line-level refill model.
module tb_m_cache_refill;

  localparam int IDX_W = 5;
  localparam int WD_W  = 89;

  logic             w_clk, w_rst_n, w_req, w_hit, w_mrdy;
  logic [31:0]      w_adr, w_mdata, w_madr;
  logic             w_stall, w_mreq, w_we;
  logic [IDX_W-1:0] w_wadr;
  logic [WD_W-1:0]  w_wd;

  int n_checks = 0;
  int n_errors = 0;

  m_cache_refill #(.IDX_W(IDX_W)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_req(w_req), .w_adr(w_adr), .w_hit(w_hit),
    .w_stall(w_stall), .w_mreq(w_mreq), .w_madr(w_madr), .w_mrdy(w_mrdy),
    .w_mdata(w_mdata), .w_we(w_we), .w_wadr(w_wadr), .w_wd(w_wd)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Line refill as the CPU sees it: two word fetches, one line write, fixed stall budget.
  task automatic do_miss(input logic [31:0] adr, input int waits, input bit chg);
    logic [31:0]     base;
    logic [31:0]     exp_a [0:2];
    logic [WD_W-1:0] exp_wd;
    int stall_cnt, fi, wl;
    bit we_seen, post;
    base = {adr[31:3], 3'b000};
`ifdef CRITICAL_WORD_FIRST_EN
    exp_a[0] = base + (adr[2] ? 32'd4 : 32'd0);
    exp_a[1] = base + (adr[2] ? 32'd0 : 32'd4);
`else
    exp_a[0] = base;
    exp_a[1] = base + 32'd4;
`endif
    exp_a[2] = 32'hDEAD_BEEF;
    exp_wd = {1'b1, adr[31:8], mem_f(base + 32'd4), mem_f(base)};
    stall_cnt = 0; fi = 0; wl = waits; we_seen = 0; post = 0;
    for (int c = 0; c < 80 && !post; c++) begin
      @(negedge w_clk);
      w_req = 1'b1;
      if (we_seen) begin
        w_adr = adr; w_hit = 1'b1;
      end else if (c == 0 || !chg) begin
        w_adr = adr; w_hit = 1'b0;
      end else begin
        w_adr = 32'hFFFF_FF00; w_hit = 1'($urandom % 2);
      end
      w_mrdy = 1'b0;
      w_mdata = $urandom;
      #1;
      if (we_seen) begin
        chk("stall_after_fill", w_stall, 0);
        chk("mreq_after_fill", w_mreq, 0);
        post = 1;
      end else begin
        if (w_stall) stall_cnt++;
        if (w_mreq) begin
          chk("madr", w_madr, exp_a[fi]);
          if (wl == 0) begin
            w_mrdy = 1'b1;
            w_mdata = mem_f(w_madr);
            if (fi < 2) fi++;
            wl = waits;
          end else begin
            wl--;
          end
        end else begin
          w_mrdy = 1'($urandom % 2);
        end
        if (w_we) begin
          we_seen = 1;
          chk("wadr", w_wadr, adr[IDX_W+2:3]);
          chk("wd", w_wd, exp_wd);
        end
      end
    end
    if (!post) chk("refill_timeout", 0, 1);
    chk("fetch_count", fi, 2);
    chk("stall_cycles", stall_cnt, 2 + 2 * (waits + 1));
  endtask

  task automatic do_hits(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge w_clk);
      w_req = 1'b1; w_hit = 1'b1; w_adr = $urandom;
      w_mrdy = 1'($urandom % 2); w_mdata = $urandom;
      #1;
      chk("hit_stall", w_stall, 0);
      chk("hit_mreq", w_mreq, 0);
      chk("hit_we", w_we, 0);
    end
  endtask

  task automatic reset_in_fetch1(input logic [31:0] adr);
    logic [31:0] second;
    bit reached;
    reached = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    second = {adr[31:3], ~adr[2], 2'b00};
`else
    second = {adr[31:3], 3'b100};
`endif
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge w_clk);
      w_req = 1'b1; w_hit = 1'b0; w_adr = adr; w_mrdy = 1'b0;
      #1;
      if (w_mreq && w_madr == second) reached = 1;
      else if (w_mreq) begin w_mrdy = 1'b1; w_mdata = mem_f(w_madr); end
    end
    chk("reach_fetch1", reached, 1);
    w_req = 1'b0; w_mrdy = 1'b0;
    w_rst_n = 1'b0;
    #1;
    chk("rst_mreq", w_mreq, 0);
    chk("rst_madr", w_madr, 0);
    chk("rst_we", w_we, 0);
    chk("rst_wd", w_wd, 0);
    chk("rst_stall", w_stall, 0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge w_clk);
      w_mrdy = 1'($urandom % 2);
      #1;
      chk("post_rst_we", w_we, 0);
      chk("post_rst_mreq", w_mreq, 0);
      chk("post_rst_stall", w_stall, 0);
    end
  endtask

  initial begin
    w_rst_n = 1'b0; w_req = 1'b0; w_hit = 1'b0; w_adr = '0;
    w_mrdy = 1'b0; w_mdata = '0;
    #12;
    chk("reset_mreq", w_mreq, 0);
    chk("reset_we", w_we, 0);
    chk("reset_madr", w_madr, 0);
    chk("reset_wadr", w_wadr, 0);
    chk("reset_wd", w_wd, 0);
    @(negedge w_clk);
    w_rst_n = 1'b1;

    do_miss(32'h0000_1234, 0, 0);
    do_miss(32'h0000_1234, 3, 0);
    do_miss(32'h0000_1230, 1, 1);
    do_hits(6);
    reset_in_fetch1(32'h0000_1234);
    do_miss(32'h0000_1234, 0, 0);
    for (int i = 0; i < 12; i++) begin
      do_miss($urandom, int'($urandom_range(0, 3)), 1'($urandom % 2));
      if ($urandom % 2) do_hits(2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
